// File: rtl/dram_cmd_sequencer.sv
// dram_cmd_sequencer: turns one read/write request at a time into spaced
// ACT/PR/RD(A)/WR(A) pulses, tracks open rows and inserts all-bank refresh.
module dram_cmd_sequencer #(
    parameter int BGWIDTH    = 2,
    parameter int BANKGROUPS = 2**BGWIDTH,
    parameter int BAWIDTH    = 2,
    parameter int ROWWIDTH   = 16,
    parameter int BL         = 8,
    parameter int T_RCD      = 17,
    parameter int T_RP       = 17,
    parameter int T_WR       = 14,
    parameter int T_RFC      = 34,
    parameter int T_REFI     = 10400
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_ap,
    input  logic [BGWIDTH-1:0]  req_bg,
    input  logic [BAWIDTH-1:0]  req_ba,
    input  logic [ROWWIDTH-1:0] req_row,
    output logic [BGWIDTH-1:0]  bg,
    output logic [BAWIDTH-1:0]  ba,
    output logic [ROWWIDTH-1:0] row,
    output logic [18:0]         commands,
    output logic                ref_pending
);

    localparam int NBANK = BANKGROUPS * (2**BAWIDTH);
    localparam int IW    = BGWIDTH + BAWIDTH;

    // Longest single wait decides the spacing counter width.
    localparam int W_RD = BL + T_RP;
    localparam int W_WR = T_WR + T_RP;
    localparam int M1   = (W_RD > W_WR) ? W_RD : W_WR;
    localparam int M2   = (T_RFC > M1) ? T_RFC : M1;
    localparam int M3   = (T_RCD > M2) ? T_RCD : M2;
    localparam int CW   = (M3 > 1) ? $clog2(M3) : 1;
    localparam int RW   = (T_REFI > 1) ? $clog2(T_REFI) : 1;

    localparam logic [CW-1:0] L_RCD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] L_RP  = CW'(T_RP - 1);
    localparam logic [CW-1:0] L_WR  = CW'(T_WR - 1);
    localparam logic [CW-1:0] L_BL  = CW'(BL - 1);
    localparam logic [CW-1:0] L_RFC = CW'(T_RFC - 1);
    localparam logic [RW-1:0] L_REFI = RW'(T_REFI - 1);

    // Bit positions inside the commands vector.
    localparam int B_ACT = 18;
    localparam int B_PR  = 7;
    localparam int B_PRA = 6;
    localparam int B_RD  = 5;
    localparam int B_RDA = 4;
    localparam int B_REF = 3;
    localparam int B_WR  = 1;
    localparam int B_WRA = 0;

    // Each waiting state names the command that was just issued.
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_COL,
        S_WAIT,
        S_RPRE,
        S_REFR
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic                lat_write;
    logic                lat_ap;
    logic [BGWIDTH-1:0]  lat_bg;
    logic [BAWIDTH-1:0]  lat_ba;
    logic [ROWWIDTH-1:0] lat_row;

    logic [NBANK-1:0]    tbl_valid;
    logic [ROWWIDTH-1:0] tbl_row [NBANK];

    logic [RW-1:0] refc_q;
    logic          refc_wrap;
    logic          ref_clr;
    logic          ref_pending_q, ref_pending_d;

    logic [18:0]         cmd_q, cmd_d;
    logic [BGWIDTH-1:0]  bg_q, bg_d;
    logic [BAWIDTH-1:0]  ba_q, ba_d;
    logic [ROWWIDTH-1:0] row_q, row_d;
    logic                ready_q, ready_d;

    logic [IW-1:0] req_idx;
    logic [IW-1:0] cmd_idx;
    logic          accept;
    logic          req_open;
    logic          req_hit;
    logic          any_open;
    logic          cnt_zero;

    function automatic logic [18:0] col_cmd(input logic w, input logic ap);
        logic [18:0] c;
        c = '0;
        unique case ({w, ap})
            2'b00:   c[B_RD]  = 1'b1;
            2'b01:   c[B_RDA] = 1'b1;
            2'b10:   c[B_WR]  = 1'b1;
            default: c[B_WRA] = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic [CW-1:0] col_wait(input logic w);
        return w ? L_WR : L_BL;
    endfunction

    assign req_idx  = {req_bg, req_ba};
    assign cmd_idx  = {bg_d, ba_d};
    assign accept   = (state_q == S_IDLE) && !ref_pending_q &&
                      req_valid && ready_q;
    assign req_open = tbl_valid[req_idx];
    assign req_hit  = req_open && (tbl_row[req_idx] == req_row);
    assign any_open = |tbl_valid;
    assign cnt_zero = (cnt_q == '0);

    assign refc_wrap     = (refc_q == L_REFI);
    assign ref_clr       = (state_q == S_REFR) && cnt_zero;
    // A wrap while a refresh is still owed is dropped, not queued.
    assign ref_pending_d = (ref_pending_q && !ref_clr) ||
                           (refc_wrap && !ref_pending_q);

    // State register, spacing counter and latched request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lat_write <= 1'b0;
            lat_ap    <= 1'b0;
            lat_bg    <= '0;
            lat_ba    <= '0;
            lat_row   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_write <= req_write;
                lat_ap    <= req_ap;
                lat_bg    <= req_bg;
                lat_ba    <= req_ba;
                lat_row   <= req_row;
            end
        end
    end

    // Next-state and counter reload on every command issue.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? '0 : cnt_q - 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
                    if (any_open) begin
                        state_d = S_RPRE;
                        cnt_d   = L_RP;
                    end else begin
                        state_d = S_REFR;
                        cnt_d   = L_RFC;
                    end
                end else if (accept) begin
                    if (req_hit) begin
                        state_d = S_COL;
                        cnt_d   = col_wait(req_write);
                    end else if (!req_open) begin
                        state_d = S_ACT;
                        cnt_d   = L_RCD;
                    end else begin
                        state_d = S_PRE;
                        cnt_d   = L_RP;
                    end
                end
            end
            S_PRE: begin
                if (cnt_zero) begin
                    state_d = S_ACT;
                    cnt_d   = L_RCD;
                end
            end
            S_ACT: begin
                if (cnt_zero) begin
                    state_d = S_COL;
                    cnt_d   = col_wait(lat_write);
                end
            end
            S_COL: begin
                if (cnt_zero) begin
                    if (lat_ap) begin
                        state_d = S_WAIT;
                        cnt_d   = L_RP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_zero) state_d = S_IDLE;
            end
            S_RPRE: begin
                if (cnt_zero) begin
                    state_d = S_REFR;
                    cnt_d   = L_RFC;
                end
            end
            S_REFR: begin
                if (cnt_zero) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command pulse and address for the edge that leaves the current state.
    always_comb begin
        cmd_d   = '0;
        bg_d    = '0;
        ba_d    = '0;
        row_d   = '0;
        ready_d = (state_d == S_IDLE) && !ref_pending_d;
        unique case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
                    if (any_open) cmd_d[B_PRA] = 1'b1;
                    else          cmd_d[B_REF] = 1'b1;
                end else if (accept) begin
                    bg_d = req_bg;
                    ba_d = req_ba;
                    if (req_hit) begin
                        cmd_d = col_cmd(req_write, req_ap);
                    end else if (!req_open) begin
                        cmd_d[B_ACT] = 1'b1;
                        row_d        = req_row;
                    end else begin
                        cmd_d[B_PR] = 1'b1;
                    end
                end
            end
            S_PRE: begin
                if (cnt_zero) begin
                    cmd_d[B_ACT] = 1'b1;
                    bg_d         = lat_bg;
                    ba_d         = lat_ba;
                    row_d        = lat_row;
                end
            end
            S_ACT: begin
                if (cnt_zero) begin
                    cmd_d = col_cmd(lat_write, lat_ap);
                    bg_d  = lat_bg;
                    ba_d  = lat_ba;
                end
            end
            S_RPRE: begin
                if (cnt_zero) cmd_d[B_REF] = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            row_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
            row_q   <= row_d;
            ready_q <= ready_d;
        end
    end

    // Open-row table follows the commands as they are issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_valid <= '0;
            for (int i = 0; i < NBANK; i++) tbl_row[i] <= '0;
        end else if (cmd_d[B_PRA]) begin
            tbl_valid <= '0;
        end else if (cmd_d[B_ACT]) begin
            tbl_valid[cmd_idx] <= 1'b1;
            tbl_row[cmd_idx]   <= row_d;
        end else if (cmd_d[B_PR] || cmd_d[B_RDA] || cmd_d[B_WRA]) begin
            tbl_valid[cmd_idx] <= 1'b0;
        end
    end

    // Free-running refresh interval counter and sticky refresh request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refc_q        <= '0;
            ref_pending_q <= 1'b0;
        end else begin
            refc_q        <= refc_wrap ? '0 : refc_q + 1'b1;
            ref_pending_q <= ref_pending_d;
        end
    end

    assign req_ready   = ready_q;
    assign commands    = cmd_q;
    assign bg          = bg_q;
    assign ba          = ba_q;
    assign row         = row_q;
    assign ref_pending = ref_pending_q;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// tb_dram_cmd_sequencer: directed request vectors with hand-computed
// command timing, plus refresh and mid-operation reset sequences.
module tb_dram_cmd_sequencer;

    localparam logic [18:0] C_ACT = 19'h40000;
    localparam logic [18:0] C_PR  = 19'h00080;
    localparam logic [18:0] C_PRA = 19'h00040;
    localparam logic [18:0] C_RD  = 19'h00020;
    localparam logic [18:0] C_RDA = 19'h00010;
    localparam logic [18:0] C_REF = 19'h00008;
    localparam logic [18:0] C_WR  = 19'h00002;
    localparam logic [18:0] C_WRA = 19'h00001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_ap = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [15:0] req_row = '0;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [18:0] commands;
    logic        ref_pending;

    dram_cmd_sequencer #(
        .BGWIDTH(2), .BAWIDTH(2), .ROWWIDTH(16), .BL(8),
        .T_RCD(17), .T_RP(17), .T_WR(14), .T_RFC(34), .T_REFI(200)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_ap(req_ap),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .bg(bg), .ba(ba), .row(row),
        .commands(commands), .ref_pending(ref_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        w;
        logic        ap;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [15:0] row;
        int          n;
        logic [18:0] c0;
        int          t0;
        logic [18:0] c1;
        int          t1;
        logic [18:0] c2;
        int          t2;
        int          rdy;
    } vec_t;

    vec_t vt [11];

    function automatic vec_t mk(
        input logic w, input logic ap,
        input logic [1:0] b_g, input logic [1:0] b_a, input logic [15:0] r,
        input int n,
        input logic [18:0] c0, input int t0,
        input logic [18:0] c1, input int t1,
        input logic [18:0] c2, input int t2,
        input int rdy);
        vec_t v;
        v.w = w; v.ap = ap; v.bg = b_g; v.ba = b_a; v.row = r; v.n = n;
        v.c0 = c0; v.t0 = t0; v.c1 = c1; v.t1 = t1;
        v.c2 = c2; v.t2 = t2; v.rdy = rdy;
        return v;
    endfunction

    function automatic logic [18:0] ec(input vec_t v, input int i);
        if (i == 0) return v.c0;
        if (i == 1) return v.c1;
        return v.c2;
    endfunction

    function automatic int et(input vec_t v, input int i);
        if (i == 0) return v.t0;
        if (i == 1) return v.t1;
        return v.t2;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!req_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: ready 0 after %0d cycles, expected 1", tag, k);
        end
    endtask

    task automatic run_req(input int vi, output int ta);
        vec_t        v;
        logic [18:0] gc [4];
        int          gt [4];
        logic [19:0] ga [4];
        int          n;
        int          rdy;
        string       tag;
        v   = vt[vi];
        tag = $sformatf("v%0d", vi);
        wait_ready(tag);
        req_write = v.w;
        req_ap    = v.ap;
        req_bg    = v.bg;
        req_ba    = v.ba;
        req_row   = v.row;
        req_valid = 1'b1;
        ta        = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        n   = 0;
        rdy = -1;
        for (int off = 1; off <= 120; off++) begin
            if (off > 1) @(negedge clk);
            if (commands != '0 && n < 4) begin
                gc[n] = commands;
                gt[n] = off;
                ga[n] = {bg, ba, row};
                n++;
            end
            if (req_ready) begin
                rdy = off;
                break;
            end
        end
        chk({tag, "_ncmd"}, n, v.n);
        for (int i = 0; i < v.n && i < n; i++) begin
            chk($sformatf("%s_cmd%0d", tag, i), gc[i], ec(v, i));
            chk($sformatf("%s_t%0d", tag, i), gt[i], et(v, i));
            chk($sformatf("%s_addr%0d", tag, i), ga[i],
                {v.bg, v.ba, (ec(v, i) == C_ACT) ? v.row : 16'h0});
        end
        chk({tag, "_ready_t"}, rdy, v.rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ta;
        int tp;
        int tr;
        int k;
        int stray;

        vt[0]  = mk(1, 0, 2'd0, 2'd1, 16'd5, 2, C_ACT, 1, C_WR, 18, '0, 0, 32);
        vt[1]  = mk(0, 0, 2'd0, 2'd1, 16'd5, 1, C_RD, 1, '0, 0, '0, 0, 9);
        vt[2]  = mk(0, 0, 2'd0, 2'd1, 16'd9, 3, C_PR, 1, C_ACT, 18, C_RD, 35, 43);
        vt[3]  = mk(1, 1, 2'd0, 2'd1, 16'd9, 1, C_WRA, 1, '0, 0, '0, 0, 32);
        vt[4]  = mk(0, 0, 2'd0, 2'd1, 16'd9, 2, C_ACT, 1, C_RD, 18, '0, 0, 26);
        vt[5]  = mk(1, 0, 2'd2, 2'd3, 16'hABCD, 2, C_ACT, 1, C_WR, 18, '0, 0, 32);
        vt[6]  = mk(0, 0, 2'd2, 2'd3, 16'hABCD, 2, C_ACT, 1, C_RD, 18, '0, 0, 26);
        vt[7]  = mk(1, 0, 2'd1, 2'd0, 16'd7, 2, C_ACT, 1, C_WR, 18, '0, 0, 32);
        vt[8]  = mk(1, 0, 2'd2, 2'd3, 16'hABCD, 2, C_ACT, 1, C_WR, 18, '0, 0, 32);
        vt[9]  = mk(0, 1, 2'd2, 2'd3, 16'hABCD, 1, C_RDA, 1, '0, 0, '0, 0, 26);
        vt[10] = mk(0, 0, 2'd2, 2'd3, 16'hABCD, 2, C_ACT, 1, C_RD, 18, '0, 0, 26);

        repeat (3) @(negedge clk);
        chk("reset_cmds", commands, 19'h0);
        chk("reset_ready", req_ready, 1'b0);
        chk("reset_refp", ref_pending, 1'b0);
        chk("reset_addr", {bg, ba, row}, 20'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1'b1);

        for (int vi = 0; vi <= 5; vi++) run_req(vi, ta);

        k = 0;
        stray = 0;
        while (!ref_pending && k < 300) begin
            @(negedge clk);
            if (commands != '0) stray++;
            k++;
        end
        chk("refresh_due", ref_pending, 1'b1);
        chk("idle_stray_cmds", stray, 0);
        chk("ready_blocked", req_ready, 1'b0);

        req_write = vt[6].w;
        req_ap    = vt[6].ap;
        req_bg    = vt[6].bg;
        req_ba    = vt[6].ba;
        req_row   = vt[6].row;
        req_valid = 1'b1;
        k = 0;
        while (commands == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("pra_cmd", {commands, bg, ba, row}, {C_PRA, 20'h0});
        tp = cyc;
        @(negedge clk);
        k = 0;
        while (commands == '0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("ref_cmd", {commands, bg, ba, row}, {C_REF, 20'h0});
        chk("pra_to_ref", cyc - tp, 17);
        tr = cyc;
        run_req(6, ta);
        chk("ref_to_ready", ta - tr, 34);

        wait_ready("abort");
        req_write = vt[7].w;
        req_ap    = vt[7].ap;
        req_bg    = vt[7].bg;
        req_ba    = vt[7].ba;
        req_row   = vt[7].row;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_act", {commands, bg, ba, row}, {C_ACT, 2'd1, 2'd0, 16'd7});
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_cmds", commands, 19'h0);
        chk("abort_ready", req_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int vi = 7; vi <= 10; vi++) run_req(vi, ta);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
